// File: rtl/sync_pulse_train_if.sv
// Handshake bundle between the start-enable stage and the pulse-train generator.
// master drives the start window level; slave returns the pulse drive and train status.
interface sync_pulse_train_if;
  logic       pt_start;
  logic       pt_o;
  logic       pt_busy;
  logic       pt_done;
  logic [7:0] pt_idx;

  modport master (
    output pt_start,
    input  pt_o,
    input  pt_busy,
    input  pt_done,
    input  pt_idx
  );

  modport slave (
    input  pt_start,
    output pt_o,
    output pt_busy,
    output pt_done,
    output pt_idx
  );
endinterface

// File: rtl/sync_pulse_train.sv
// Optical sync pulse train: N_PULSES pulses after DELAY_CYC per start rising edge; optional start synchronizer via SYNC_PULSE_TRAIN_START_SYNC_EN.
// Latency: first pulse at E+DELAY_CYC+1 (+2 with synchronizer); no backpressure, a low start window aborts the train on the next edge.
module sync_pulse_train #(
  parameter int CNT_W      = 32,
  parameter int DELAY_CYC  = 50,
  parameter int WIDTH_CYC  = 25,
  parameter int PERIOD_CYC = 50,
  parameter int N_PULSES   = 8
) (
  input  logic               pt_clk,
  input  logic               pt_rst,
  sync_pulse_train_if.slave  pt
);

  localparam bit PARAMS_OK =
      (CNT_W >= 2) && (CNT_W <= 32) &&
      (DELAY_CYC >= 0) && (WIDTH_CYC >= 1) && (PERIOD_CYC > WIDTH_CYC) &&
      (N_PULSES >= 1) && (N_PULSES <= 255) &&
      ((CNT_W >= 31) || ((DELAY_CYC < (1 << CNT_W)) && (PERIOD_CYC < (1 << CNT_W))));

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("sync_pulse_train: illegal parameter set");
    end
  endgenerate

  localparam logic [CNT_W-1:0] DLY_LAST = (DELAY_CYC > 0) ? CNT_W'(DELAY_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(WIDTH_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(PERIOD_CYC - WIDTH_CYC - 1);
  localparam logic [7:0]       IDX_LAST = 8'(N_PULSES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       idx, idx_nxt;
  logic             start_s;
  logic             start_prev;
  logic             active, abort, trigger;
  logic             o_q, o_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;

  // Synchronizer resets high so a window already open at reset release is not seen as an edge.
`ifdef SYNC_PULSE_TRAIN_START_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge pt_clk or posedge pt_rst) begin
    if (pt_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pt.pt_start};
    end
  end

  assign start_s = sync_q[1];
`else
  assign start_s = pt.pt_start;
`endif

  always_ff @(posedge pt_clk or posedge pt_rst) begin
    if (pt_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      start_prev <= 1'b1;
      o_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      start_prev <= start_s;
      o_q        <= o_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    active    = (state == ST_DELAY) || (state == ST_HIGH) || (state == ST_LOW);
    abort     = active && !start_s;
    trigger   = start_s && !start_prev;
    // Outputs are registered copies of the current state, so light lags the FSM by one edge.
    o_nxt     = (state == ST_HIGH) && !abort;
    busy_nxt  = active && !abort;
    done_nxt  = (state == ST_DONE);

    case (state)
      ST_IDLE: begin
        if (trigger) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = (DELAY_CYC == 0) ? ST_HIGH : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (cnt == DLY_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_HIGH;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt == HI_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (idx == IDX_LAST) ? ST_DONE : ST_LOW;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt == LO_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = idx + 8'd1;
          state_nxt = ST_HIGH;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort takes precedence over every transition, including the final pulse ending.
    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = idx;
    end
  end

  assign pt.pt_o    = o_q;
  assign pt.pt_busy = busy_q;
  assign pt.pt_done = done_q;
  assign pt.pt_idx  = idx;

endmodule

// File: tb/tb_sync_pulse_train.sv
// Bench for sync_pulse_train: per-edge expectations queued from a timing model, popped as the DUT advances.
module tb_sync_pulse_train;

`ifdef SYNC_PULSE_TRAIN_START_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  typedef struct packed {
    logic       o;
    logic       busy;
    logic       done;
    logic [7:0] idx;
  } exp_t;

  logic pt_clk;
  logic pt_rst;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];
  exp_t e_exp;
  exp_t e_obs;

  sync_pulse_train_if ifa ();
  sync_pulse_train_if ifb ();

  sync_pulse_train #(
    .CNT_W(32), .DELAY_CYC(3), .WIDTH_CYC(2), .PERIOD_CYC(5), .N_PULSES(3)
  ) dut_a (
    .pt_clk (pt_clk),
    .pt_rst (pt_rst),
    .pt     (ifa)
  );

  sync_pulse_train #(
    .CNT_W(32), .DELAY_CYC(0), .WIDTH_CYC(1), .PERIOD_CYC(2), .N_PULSES(1)
  ) dut_b (
    .pt_clk (pt_clk),
    .pt_rst (pt_rst),
    .pt     (ifb)
  );

  initial pt_clk = 1'b0;
  always #5 pt_clk = ~pt_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic exp_t obs_a();
    return {ifa.pt_o, ifa.pt_busy, ifa.pt_done, ifa.pt_idx};
  endfunction

  function automatic exp_t obs_b();
    return {ifb.pt_o, ifb.pt_busy, ifb.pt_done, ifb.pt_idx};
  endfunction

  function automatic logic [7:0] idx_model(input int d, input int p, input int n, input int t);
    logic [7:0] r;
    r = 8'd0;
    for (int j = 1; j < n; j++) if (d + j * p <= t) r = r + 8'd1;
    return r;
  endfunction

  // Edge k is the k-th rising edge after start is raised; a = raw edge at which start is first sampled low (-1: never).
  task automatic push_train(input int d, input int w, input int p, input int n,
                            input int a, input int ne, input logic [7:0] idx0);
    int   last, t, u;
    exp_t e;
    last = d + (n - 1) * p + w;
    for (int k = 0; k <= ne; k++) begin
      t = k - L;
      e = '0;
      if (t < 0) begin
        e.idx = idx0;
      end else begin
        e.busy = (t >= 1) && (t <= last);
        e.done = (t == last + 1);
        if (t >= d + 1) begin
          u   = t - d - 1;
          e.o = ((u / p) < n) && ((u % p) < w);
        end
        e.idx = idx_model(d, p, n, t);
        if (a >= 1 && a <= last && t >= a) begin
          e.o    = 1'b0;
          e.busy = 1'b0;
          e.done = 1'b0;
          e.idx  = idx_model(d, p, n, a - 1);
        end
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pt_clk);
    #1;
  endtask

  task automatic test_reset();
    pt_rst = 1'b1;
    ifa.pt_start = 1'b0;
    ifb.pt_start = 1'b0;
    #3;
    n_cmp++; if (ifa.pt_o !== 1'b0)    begin n_bad++; $display("FAIL reset_o got %b exp 0", ifa.pt_o); end
    n_cmp++; if (ifa.pt_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", ifa.pt_busy); end
    idle(3);
    pt_rst = 1'b0;
    idle(2);
    n_cmp++; if (ifa.pt_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", ifa.pt_done); end
    n_cmp++; if (ifa.pt_idx !== 8'd0)  begin n_bad++; $display("FAIL reset_idx got %0d exp 0", ifa.pt_idx); end
    n_cmp++; if (obs_b() !== exp_t'(0)) begin n_bad++; $display("FAIL reset_b got %h exp 0", obs_b()); end
  endtask

  task automatic test_train();
    push_train(3, 2, 5, 3, -1, L + 18, 8'd0);
    ifa.pt_start = 1'b1;
    for (int k = 0; k <= L + 18; k++) begin
      @(posedge pt_clk); #1;
      e_exp = sb_q.pop_front();
      e_obs = obs_a();
      n_cmp++;
      if (e_obs !== e_exp) begin
        n_bad++;
        $display("FAIL train k=%0d got {o,busy,done,idx}=%h exp %h", k, e_obs, e_exp);
      end
    end
    ifa.pt_start = 1'b0;
    idle(4);
  endtask

  task automatic test_abort();
    push_train(3, 2, 5, 3, 9, L + 16, 8'd2);
    ifa.pt_start = 1'b1;
    for (int k = 0; k <= L + 16; k++) begin
      @(posedge pt_clk); #1;
      e_exp = sb_q.pop_front();
      e_obs = obs_a();
      n_cmp++;
      if (e_obs !== e_exp) begin
        n_bad++;
        $display("FAIL abort k=%0d got {o,busy,done,idx}=%h exp %h", k, e_obs, e_exp);
      end
      if (k == 8) ifa.pt_start = 1'b0;
    end
    idle(4);
  endtask

  task automatic test_retrigger();
    push_train(3, 2, 5, 3, -1, L + 18, 8'd1);
    ifa.pt_start = 1'b1;
    for (int k = 0; k <= L + 18; k++) begin
      @(posedge pt_clk); #1;
      e_exp = sb_q.pop_front();
      e_obs = obs_a();
      n_cmp++;
      if (e_obs !== e_exp) begin
        n_bad++;
        $display("FAIL retrigger k=%0d got {o,busy,done,idx}=%h exp %h", k, e_obs, e_exp);
      end
      if (k == 5) begin
        #2 ifa.pt_start = 1'b0;
        #2 ifa.pt_start = 1'b1;
      end
    end
    ifa.pt_start = 1'b0;
    idle(4);
  endtask

  task automatic test_start_held_at_reset();
    ifa.pt_start = 1'b1;
    pt_rst = 1'b1;
    idle(2);
    pt_rst = 1'b0;
    repeat (20) sb_q.push_back(exp_t'(0));
    for (int k = 0; k < 20; k++) begin
      @(posedge pt_clk); #1;
      e_exp = sb_q.pop_front();
      e_obs = obs_a();
      n_cmp++;
      if (e_obs !== e_exp) begin
        n_bad++;
        $display("FAIL held_start k=%0d got {o,busy,done,idx}=%h exp %h", k, e_obs, e_exp);
      end
    end
    ifa.pt_start = 1'b0;
    idle(4);
    push_train(3, 2, 5, 3, -1, L + 18, 8'd0);
    ifa.pt_start = 1'b1;
    for (int k = 0; k <= L + 18; k++) begin
      @(posedge pt_clk); #1;
      e_exp = sb_q.pop_front();
      e_obs = obs_a();
      n_cmp++;
      if (e_obs !== e_exp) begin
        n_bad++;
        $display("FAIL held_then_toggle k=%0d got {o,busy,done,idx}=%h exp %h", k, e_obs, e_exp);
      end
    end
    ifa.pt_start = 1'b0;
    idle(4);
  endtask

  task automatic test_min_params();
    push_train(0, 1, 2, 1, -1, L + 4, 8'd0);
    ifb.pt_start = 1'b1;
    for (int k = 0; k <= L + 4; k++) begin
      @(posedge pt_clk); #1;
      e_exp = sb_q.pop_front();
      e_obs = obs_b();
      n_cmp++;
      if (e_obs !== e_exp) begin
        n_bad++;
        $display("FAIL min_params k=%0d got {o,busy,done,idx}=%h exp %h", k, e_obs, e_exp);
      end
    end
    ifb.pt_start = 1'b0;
    idle(4);
  endtask

  task automatic test_async_reset();
    push_train(3, 2, 5, 3, -1, L + 9, 8'd2);
    ifa.pt_start = 1'b1;
    for (int k = 0; k <= L + 9; k++) begin
      @(posedge pt_clk); #1;
      e_exp = sb_q.pop_front();
      e_obs = obs_a();
      n_cmp++;
      if (e_obs !== e_exp) begin
        n_bad++;
        $display("FAIL pre_reset k=%0d got {o,busy,done,idx}=%h exp %h", k, e_obs, e_exp);
      end
    end
    #2 pt_rst = 1'b1;
    #1;
    n_cmp++; if (ifa.pt_o !== 1'b0)    begin n_bad++; $display("FAIL async_rst_o got %b exp 0", ifa.pt_o); end
    n_cmp++; if (ifa.pt_busy !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy got %b exp 0", ifa.pt_busy); end
    n_cmp++; if (ifa.pt_idx !== 8'd0)  begin n_bad++; $display("FAIL async_rst_idx got %0d exp 0", ifa.pt_idx); end
    n_cmp++; if (ifa.pt_done !== 1'b0) begin n_bad++; $display("FAIL async_rst_done got %b exp 0", ifa.pt_done); end
    ifa.pt_start = 1'b0;
    idle(2);
    pt_rst = 1'b0;
    idle(3);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_train();
    test_abort();
    test_retrigger();
    test_start_held_at_reset();
    test_min_params();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
